// File: rtl/mem_addr_unit_pkg.sv
// Shared types and codes for the data-memory address unit: FSM states, fault codes and
// access-size codes, plus the alignment rule used when alignment checking is built in.
package mem_addr_unit_pkg;

    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StBusy = 2'd1;
    localparam state_t StResp = 2'd2;

    typedef logic [1:0] fault_t;
    localparam fault_t FaultNone    = 2'b00;
    localparam fault_t FaultRange   = 2'b01;
    localparam fault_t FaultAlign   = 2'b10;
    localparam fault_t FaultTimeout = 2'b11;

    typedef logic [1:0] size_t;
    localparam size_t SizeByte = 2'b00;
    localparam size_t SizeHalf = 2'b01;
    localparam size_t SizeWord = 2'b10;
    localparam size_t SizeRsvd = 2'b11;

    // Reserved size is handled exactly like a word access.
    function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SizeByte: mis = 1'b0;
            SizeHalf: mis = addr_lo[0];
            default:  mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_be_decode.sv
// Combinational byte-enable decode from access size and the low two address bits.
// Lanes shifted past bit 3 fall off the 4-bit result.
module mem_be_decode
    import mem_addr_unit_pkg::*;
(
    input  logic [1:0] addr_i,
    input  logic [1:0] size_i,
    output logic [3:0] be_o
);

    always_comb begin
        be_o = 4'b1111;
        case (size_i)
            SizeByte: be_o = 4'b0001 << addr_i;
            SizeHalf: be_o = 4'b0011 << addr_i;
            default:  be_o = 4'b1111;
        endcase
    end

endmodule

// File: rtl/mem_addr_unit.sv
// Data-memory address unit: range-checks and reduces the ALU address, issues a held memory
// request and reports completion/fault. Define MEM_ADDR_ALIGN_CHECK_EN to add misalignment faults.
module mem_addr_unit
    import mem_addr_unit_pkg::*;
#(
    parameter int unsigned ADDR_IN_W  = 32,
    parameter int unsigned ADDR_OUT_W = 8,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic [ADDR_IN_W-1:0]  alu_out,
    output logic                  mem_req,
    output logic [ADDR_OUT_W-1:0] mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    output logic                  done,
    output logic [1:0]            fault
);

    state_t                state_q, state_d;
    logic [ADDR_OUT_W-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [7:0]            cnt_q, cnt_d;
    fault_t                fault_q, fault_d;

    logic       range_err;
    logic       align_err;
    logic [3:0] be_dec;
    logic [8:0] cnt_inc;

    mem_be_decode u_be_decode (
        .addr_i (alu_out[1:0]),
        .size_i (req_size),
        .be_o   (be_dec)
    );

    generate
        if (ADDR_OUT_W < ADDR_IN_W) begin : g_range
            assign range_err = |alu_out[ADDR_IN_W-1:ADDR_OUT_W];
        end else begin : g_no_range
            assign range_err = 1'b0;
        end
    endgenerate

`ifdef MEM_ADDR_ALIGN_CHECK_EN
    assign align_err = is_misaligned(req_size, alu_out[1:0]);
`else
    assign align_err = 1'b0;
`endif

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (req_valid) begin
                    addr_d = alu_out[ADDR_OUT_W-1:0];
                    we_d   = req_we;
                    be_d   = be_dec;
                    // Range outranks alignment; either one skips the memory request.
                    if (range_err) begin
                        state_d = StResp;
                        fault_d = FaultRange;
                    end else if (align_err) begin
                        state_d = StResp;
                        fault_d = FaultAlign;
                    end else begin
                        state_d = StBusy;
                        fault_d = FaultNone;
                    end
                end
            end
            StBusy: begin
                // An ack arriving on the timeout cycle still completes cleanly.
                if (mem_ack) begin
                    state_d = StResp;
                    fault_d = FaultNone;
                end else if (cnt_inc == 9'(TIMEOUT)) begin
                    state_d = StResp;
                    fault_d = FaultTimeout;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            StResp: begin
                state_d = StIdle;
                fault_d = FaultNone;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                fault_d = FaultNone;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            cnt_q   <= '0;
            fault_q <= FaultNone;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign mem_req   = (state_q == StBusy);
    assign done      = (state_q == StResp);
    assign fault     = fault_q;
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_be    = be_q;

endmodule

// File: tb/tb_mem_addr_unit.sv
// Self-checking bench for mem_addr_unit: directed cases plus random transactions against a
// size-in-bytes reference model of addressing, faults, request length and done latency.
module tb_mem_addr_unit;

    localparam int unsigned AIW = 32;
    localparam int unsigned AOW = 8;
    localparam int unsigned TO  = 15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic [AIW-1:0]  alu_out;
    logic            mem_req;
    logic [AOW-1:0]  mem_addr;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic            mem_ack;
    logic            done;
    logic [1:0]      fault;

    int errors = 0;
    int checks = 0;

    mem_addr_unit #(
        .ADDR_IN_W  (AIW),
        .ADDR_OUT_W (AOW),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .alu_out   (alu_out),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .done      (done),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: access covers 'bytes' consecutive lanes starting at the low address bits.
    function automatic void model(input logic [31:0] a, input logic [1:0] sz, input int ack_after,
                                  output logic [3:0] be, output logic [1:0] flt, output int nreq);
        int bytes;
        int sh;
        bit mis;
        bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        sh    = int'(a[1:0]);
        be    = (bytes == 4) ? 4'hF : 4'((((1 << bytes) - 1) << sh) & 15);
`ifdef MEM_ADDR_ALIGN_CHECK_EN
        mis = (sh % bytes) != 0;
`else
        mis = 1'b0;
`endif
        if (a >= 32'(1 << AOW)) begin
            flt = 2'd1; nreq = 0;
        end else if (mis) begin
            flt = 2'd2; nreq = 0;
        end else if (ack_after < int'(TO)) begin
            flt = 2'd0; nreq = ack_after + 1;
        end else begin
            flt = 2'd3; nreq = int'(TO);
        end
    endfunction

    // Called and returns at a negedge with the unit idle.
    task automatic run_txn(input string tag, input logic [31:0] a, input logic we,
                           input logic [1:0] sz, input int ack_after);
        logic [3:0] exp_be;
        logic [1:0] exp_flt;
        logic [1:0] flt_seen;
        int         exp_nreq;
        int         nreq;
        int         lat;
        bit         got;
        model(a, sz, ack_after, exp_be, exp_flt, exp_nreq);
        check({tag, ":ready"}, 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        alu_out   = a;
        @(posedge clk);
        @(negedge clk);
        // Scrambled request inputs outside IDLE must be ignored.
        req_valid = 1'($urandom);
        req_we    = 1'($urandom);
        req_size  = 2'($urandom);
        alu_out   = $urandom;
        nreq = 0; lat = 0; got = 0; flt_seen = 2'd0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (c > 0) @(negedge clk);
            lat++;
            if (done) begin
                got      = 1;
                flt_seen = fault;
                mem_ack  = 1'($urandom);
            end else if (mem_req) begin
                check({tag, ":bus"}, 64'({mem_addr, mem_we, mem_be}), 64'({a[7:0], we, exp_be}));
                mem_ack = (nreq == ack_after);
                nreq++;
            end else begin
                mem_ack = 1'($urandom);
            end
        end
        req_valid = 1'b0;
        check({tag, ":done_seen"}, 64'(got), 64'(1));
        check({tag, ":fault"}, 64'(flt_seen), 64'(exp_flt));
        check({tag, ":nreq"}, 64'(nreq), 64'(exp_nreq));
        check({tag, ":latency"}, 64'(lat), 64'((exp_nreq == 0) ? 1 : exp_nreq + 1));
        @(negedge clk);
        mem_ack = 1'b0;
        check({tag, ":done_one_cycle"}, 64'({done, req_ready}), 64'(2'b01));
    endtask

    initial begin
        logic [31:0] ra;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'd0;
        alu_out   = '0;
        mem_ack   = 1'b0;
        #1;
        check("reset_outputs", 64'({req_ready, mem_req, done, fault, mem_addr, mem_we, mem_be}),
              64'({1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0}));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("word_load_44", 32'h0000_0044, 1'b0, 2'd2, 0);
        run_txn("byte_store_13", 32'h0000_0013, 1'b1, 2'd0, 2);
        run_txn("range_100", 32'h0000_0100, 1'b0, 2'd2, 0);
        run_txn("range_high", 32'h8000_0004, 1'b1, 2'd0, 0);
        run_txn("timeout", 32'h0000_0020, 1'b0, 2'd2, 99);
        run_txn("ack_at_15", 32'h0000_0020, 1'b1, 2'd2, 14);
        run_txn("half_05", 32'h0000_0005, 1'b0, 2'd1, 1);
        run_txn("half_03", 32'h0000_0003, 1'b1, 2'd1, 0);
        run_txn("rsvd_08", 32'h0000_0008, 1'b0, 2'd3, 3);
        run_txn("rsvd_0a", 32'h0000_000A, 1'b0, 2'd3, 0);
        run_txn("byte_ff", 32'h0000_00FF, 1'b1, 2'd0, 5);

        // Reset during the third BUSY cycle abandons the request.
        check("rst_ready", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        alu_out   = 32'h0000_0058;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy3_req", 64'(mem_req), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'({req_ready, mem_req, done, fault, mem_addr, mem_we, mem_be}),
              64'({1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0}));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_ready", 64'(req_ready), 64'(1));
        begin
            int dones = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done || mem_req) dones++;
            end
            check("rst_no_done", 64'(dones), 64'(0));
        end

        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra = ra & 32'h0000_00FF;
            run_txn("rand", ra, 1'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 17));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
